// File: rtl/kernel_addr_scanner_if.sv
// Coordinate stream from the scanner to a 3-row kernel operator: valid/ready handshake
// carrying the column and centre-row address of each beat.
interface kernel_addr_scanner_if #(
  parameter int AW = 8
);
  logic          valid;
  logic          ready;
  logic [AW-1:0] address_width;
  logic [AW-1:0] address_depth;

  modport master (
    output valid,
    output address_width,
    output address_depth,
    input  ready
  );

  modport slave (
    input  valid,
    input  address_width,
    input  address_depth,
    output ready
  );
endinterface

// File: rtl/kernel_addr_scanner.sv
// Raster-order kernel centre scanner: one start yields a frame of coordinates, held while ready=0.
// KERNEL_SCAN_BORDER_SKIP_EN restricts centre rows to 1..IMG_DEPTH-2; otherwise every row is scanned.
module kernel_addr_scanner #(
  parameter int IMG_WIDTH = 64,
  parameter int IMG_DEPTH = 64,
  parameter int AW        = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  kernel_addr_scanner_if.master   bus
);

  localparam logic [AW-1:0] W_LAST  = AW'(IMG_WIDTH - 1);
`ifdef KERNEL_SCAN_BORDER_SKIP_EN
  localparam logic [AW-1:0] D_FIRST = AW'(1);
  localparam logic [AW-1:0] D_LAST  = AW'(IMG_DEPTH - 2);
`else
  localparam logic [AW-1:0] D_FIRST = AW'(0);
  localparam logic [AW-1:0] D_LAST  = AW'(IMG_DEPTH - 1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic          valid_q;
  logic [AW-1:0] col_q;
  logic [AW-1:0] row_q;

  assign bus.valid         = valid_q;
  assign bus.address_width = col_q;
  assign bus.address_depth = row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SCAN;
            valid_q <= 1'b1;
            col_q   <= '0;
            row_q   <= D_FIRST;
            busy    <= 1'b1;
          end
        end
        SCAN: begin
          // Abort takes priority; a coincident handshake is treated as consumed.
          if (abort) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy    <= 1'b0;
          end else if (bus.ready) begin
            if (col_q == W_LAST) begin
              col_q <= '0;
              if (row_q == D_LAST) begin
                state   <= DONE;
                valid_q <= 1'b0;
                done    <= 1'b1;
              end else begin
                row_q <= row_q + AW'(1);
              end
            end else begin
              col_q <= col_q + AW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
